// File: rtl/hc_sr04_emu.sv
// HC-SR04 ultrasonic ranger emulator: answers a trig pulse with an echo whose width
// encodes the configured target distance, including burst delay and post-echo dead time.
module hc_sr04_emu #(
    parameter int unsigned CLK_PER_US  = 24,
    parameter int unsigned TRIG_MIN_US = 10,
    parameter int unsigned BURST_US    = 200,
    parameter int unsigned CM_US       = 58,
    parameter int unsigned MAX_ECHO_US = 38000,
    parameter int unsigned HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       trig,
    input  logic [8:0] dist_cm,
    output logic       echo,
    output logic       busy,
    output logic       done,
    output logic       trig_err
);

    localparam int unsigned CW = 32;
    localparam logic [CW-1:0] TRIG_CYC  = CW'(TRIG_MIN_US * CLK_PER_US);
    localparam logic [CW-1:0] BURST_CYC = CW'(BURST_US * CLK_PER_US);
    localparam logic [CW-1:0] HOLD_CYC  = CW'(HOLDOFF_US * CLK_PER_US);
    localparam logic [CW-1:0] MAX_CYC   = CW'(MAX_ECHO_US * CLK_PER_US);
    localparam logic [CW-1:0] CM_CYC    = CW'(CM_US * CLK_PER_US);
    localparam logic [CW-1:0] MIN_CYC   = CW'(2 * CM_US * CLK_PER_US);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_BURST,
        ST_ECHO,
        ST_HOLDOFF
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] echo_len;
    logic [8:0]    dist_q;
    logic          sync1, sync2, sync3;
    logic [1:0]    vld;
    logic          armed;
    logic          rise, fall;
    logic          cnt_clr, cnt_inc, latch, err_ev;

    // armed only after the synchronizer has been seen low, so a trig held high
    // through reset never looks like a rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            vld   <= '0;
            armed <= 1'b0;
        end else begin
            sync1 <= trig;
            sync2 <= sync1;
            sync3 <= sync2;
            vld   <= {vld[0], 1'b1};
            armed <= armed | (vld[1] & ~sync2);
        end
    end

    assign rise = armed & sync2 & ~sync3;
    assign fall = ~sync2 & sync3;

    always_comb begin
        if (dist_q > 9'd400)
            echo_len = MAX_CYC;
        else if (dist_q < 9'd2)
            echo_len = MIN_CYC;
        else
            echo_len = CW'(dist_q) * CM_CYC;
    end

    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        latch      = 1'b0;
        err_ev     = 1'b0;
        if (!en) begin
            next_state = ST_IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        next_state = ST_TRIG;
                        cnt_clr    = 1'b1;
                    end
                end
                ST_TRIG: begin
                    // the high cycle spent detecting the edge in IDLE counts as the first one
                    if (fall) begin
                        cnt_clr = 1'b1;
                        if (cnt + CW'(1) >= TRIG_CYC) begin
                            next_state = ST_BURST;
                            latch      = 1'b1;
                        end else begin
                            next_state = ST_IDLE;
                            err_ev     = 1'b1;
                        end
                    end else if (sync2 && cnt < TRIG_CYC) begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (cnt == BURST_CYC - CW'(1)) begin
                        next_state = ST_ECHO;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_ECHO: begin
                    if (cnt == echo_len - CW'(1)) begin
                        next_state = ST_HOLDOFF;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLD_CYC - CW'(1)) begin
                        next_state = ST_IDLE;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // outputs are registered images of the current state, one cycle behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            dist_q   <= '0;
            echo     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CW'(1);
            if (latch)
                dist_q <= dist_cm;
            echo     <= en && (state == ST_ECHO);
            busy     <= en && (state != ST_IDLE);
            done     <= en && (state == ST_HOLDOFF) && echo;
            trig_err <= err_ev;
        end
    end

endmodule

// File: tb/tb_hc_sr04_emu.sv
// Self-checking bench for hc_sr04_emu with scaled-down timing parameters so that
// full echo/holdoff cycles fit a short run.
module tb_hc_sr04_emu;

    localparam int CPU  = 2;
    localparam int TMIN = 3;
    localparam int BUS  = 5;
    localparam int CMU  = 1;
    localparam int MAXU = 500;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       trig = 1'b0;
    logic [8:0] dist_cm = '0;
    logic       echo, busy, done, trig_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_lat, m_width, m_done, m_err, m_tail, m_dfall;
    bit m_seen, m_to, m_post, m_regap;

    typedef struct {
        int w;
        int d;
        bit err;
        int len;
    } vec_t;
    vec_t tab[9];

    hc_sr04_emu #(
        .CLK_PER_US (CPU),
        .TRIG_MIN_US(TMIN),
        .BURST_US   (BUS),
        .CM_US      (CMU),
        .MAX_ECHO_US(MAXU),
        .HOLDOFF_US (HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .trig    (trig),
        .dist_cm (dist_cm),
        .echo    (echo),
        .busy    (busy),
        .done    (done),
        .trig_err(trig_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_len(input int d);
        if (d > 400) return MAXU * CPU;
        if (d < 2) return 2 * CMU * CPU;
        return d * CMU * CPU;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // one trig pulse of w cycles, then watch the response until busy falls
    task automatic do_meas(input int w, input int d, input int mode);
        int  t0, rel, fall_rel;
        bit  fell;
        m_lat = -1; m_width = 0; m_done = 0; m_err = 0; m_tail = -1; m_dfall = 0;
        m_seen = 0; m_to = 1; m_post = 0; m_regap = 0; fell = 0; fall_rel = 0;
        dist_cm = 9'(d);
        trig = 1'b1;
        repeat (w) tick;
        trig = 1'b0;
        t0 = cyc + 1;
        for (int k = 0; k < 1500; k++) begin
            if (mode == 1) begin
                if (k == 5) dist_cm = 9'd50;
                if (k == 20 || k == 218) trig = 1'b1;
                if (k == 30 || k == 222) trig = 1'b0;
            end
            tick;
            rel = cyc - t0;
            m_err  += int'(trig_err);
            m_done += int'(done);
            if (echo) begin
                if (!m_seen) begin
                    m_seen = 1;
                    m_lat  = rel;
                end
                if (fell) m_regap = 1;
                m_width++;
            end else if (m_seen && !fell) begin
                fell     = 1;
                fall_rel = rel;
                m_dfall  = int'(done);
            end
            if (fell && !busy) begin
                m_tail = rel - fall_rel;
                m_to   = 0;
                break;
            end
            if (!m_seen && rel >= 40) begin
                m_to = 0;
                break;
            end
        end
        repeat (10) begin
            tick;
            if (busy || echo) m_post = 1;
            m_err  += int'(trig_err);
            m_done += int'(done);
        end
    endtask

    task automatic check_meas(input string name, input bit exp_err, input int exp_len);
        if (exp_err) begin
            check({name, ".trig_err"}, m_err, 1);
            check({name, ".echo_seen"}, 32'(m_seen), 0);
            check({name, ".done"}, m_done, 0);
            check({name, ".idle_after"}, 32'(m_post), 0);
        end else begin
            check({name, ".timeout"}, 32'(m_to), 0);
            check({name, ".latency"}, m_lat, 3 + BUS * CPU);
            check({name, ".width"}, m_width, exp_len);
            check({name, ".contiguous"}, 32'(m_regap), 0);
            check({name, ".done_count"}, m_done, 1);
            check({name, ".done_at_fall"}, m_dfall, 1);
            check({name, ".busy_tail"}, m_tail, HOLD * CPU);
            check({name, ".trig_err"}, m_err, 0);
            check({name, ".idle_after"}, 32'(m_post), 0);
        end
    endtask

    initial begin
        int cnt_e, cnt_b, cnt_d;
        int w, d;

        tab[0] = '{6, 100, 0, 200};
        tab[1] = '{5, 100, 1, 0};
        tab[2] = '{6, 0, 0, 4};
        tab[3] = '{6, 1, 0, 4};
        tab[4] = '{6, 2, 0, 4};
        tab[5] = '{6, 400, 0, 800};
        tab[6] = '{6, 401, 0, 1000};
        tab[7] = '{6, 511, 0, 1000};
        tab[8] = '{9, 37, 0, 74};

        repeat (3) tick;
        check("reset.echo", echo, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.trig_err", trig_err, 0);
        rst_n = 1'b1;
        en = 1'b1;
        repeat (5) tick;

        for (int i = 0; i < 9; i++) begin
            do_meas(tab[i].w, tab[i].d, 0);
            check_meas($sformatf("vec%0d", i), tab[i].err, tab[i].len);
        end

        // retrigger during echo and holdoff, distance changed mid-burst
        do_meas(6, 100, 1);
        check_meas("ignore_retrig", 0, 200);

        // reset mid-echo with trig held high across it
        dist_cm = 9'd100;
        trig = 1'b1;
        repeat (6) tick;
        trig = 1'b0;
        repeat (60) tick;
        check("rst.echo_before", echo, 1);
        trig = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst.echo_now", echo, 0);
        check("rst.busy_now", busy, 0);
        check("rst.done_now", done, 0);
        tick;
        tick;
        rst_n = 1'b1;
        cnt_e = 0; cnt_b = 0; cnt_d = 0;
        repeat (60) begin
            tick;
            cnt_e += int'(echo); cnt_b += int'(busy); cnt_d += int'(done);
        end
        trig = 1'b0;
        repeat (20) begin
            tick;
            cnt_e += int'(echo); cnt_b += int'(busy); cnt_d += int'(done);
        end
        check("rst.held_trig_echo", cnt_e, 0);
        check("rst.held_trig_busy", cnt_b, 0);
        check("rst.no_done", cnt_d, 0);
        do_meas(6, 100, 0);
        check_meas("after_rst", 0, 200);

        // en drop mid-echo, then en raised while trig already high
        trig = 1'b1;
        repeat (6) tick;
        trig = 1'b0;
        repeat (50) tick;
        check("en.echo_before", echo, 1);
        en = 1'b0;
        tick;
        check("en.echo_next", echo, 0);
        check("en.busy_next", busy, 0);
        cnt_d = int'(done);
        trig = 1'b1;
        repeat (20) begin
            tick;
            cnt_d += int'(done);
        end
        en = 1'b1;
        cnt_b = 0; cnt_e = 0;
        repeat (30) begin
            tick;
            cnt_b += int'(busy); cnt_e += int'(echo); cnt_d += int'(done);
        end
        trig = 1'b0;
        repeat (10) begin
            tick;
            cnt_b += int'(busy); cnt_e += int'(echo); cnt_d += int'(done);
        end
        check("en.no_done", cnt_d, 0);
        check("en.held_trig_busy", cnt_b, 0);
        check("en.held_trig_echo", cnt_e, 0);

        // loopback sweep of distances against the reference formula
        for (int dd = 2; dd <= 400; dd += 37) begin
            do_meas(6, dd, 0);
            check_meas($sformatf("sweep_d%0d", dd), 0, model_len(dd));
        end
        do_meas(6, 400, 0);
        check_meas("sweep_d400", 0, model_len(400));

        // randomized pulse widths and distances
        for (int r = 0; r < 20; r++) begin
            w = int'($urandom_range(3, 9));
            d = int'($urandom_range(0, 511));
            do_meas(w, d, 0);
            check_meas($sformatf("rand%0d_w%0d_d%0d", r, w, d), (w < TMIN * CPU), model_len(d));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
